// File: rtl/cvxif_pkg.sv
// Shared types for the CV-X-IF convolution decoder: per-slot config, issue response,
// funct3 encodings and FSM states.
package cvxif_pkg;

  localparam int unsigned CV_XLEN  = 32;
  localparam int unsigned CV_DIM_W = 16;
  localparam int unsigned CV_CH_W  = 5;
  localparam int unsigned MASK_W   = 4;

  localparam logic [2:0] F3_SETADDR  = 3'b000;
  localparam logic [2:0] F3_SETIDIM  = 3'b001;
  localparam logic [2:0] F3_SETWDIM  = 3'b010;
  localparam logic [2:0] F3_SETRADDR = 3'b011;
  localparam logic [2:0] F3_START    = 3'b100;
  localparam logic [2:0] F3_STATUS   = 3'b101;
  localparam logic [2:0] F3_PERF     = 3'b110;
  localparam logic [2:0] F3_CLR      = 3'b111;

  localparam logic [CV_XLEN-1:0] ERR_INCOMPLETE = CV_XLEN'(1);

  typedef struct packed {
    logic [CV_XLEN-1:0]  w_addr;
    logic [CV_XLEN-1:0]  i_addr;
    logic [CV_XLEN-1:0]  r_addr;
    logic [CV_DIM_W-1:0] i_height;
    logic [CV_DIM_W-1:0] i_width;
    logic [CV_CH_W-1:0]  i_channels;
    logic [CV_DIM_W-1:0] w_height;
    logic [CV_DIM_W-1:0] w_width;
    logic [CV_CH_W-1:0]  w_channels;
    logic [1:0]          padding;
    logic                stride;
  } conv_cfg_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RESP   = 2'd2
  } dec_state_e;

endpackage

// File: rtl/co_cfg_bank.sv
// Convolution config register file: one conv_cfg_t plus a 4-bit written-field mask per slot.
module co_cfg_bank
  import cvxif_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SLOT_W    = $clog2(NUM_SLOTS),
  parameter int unsigned XLEN      = CV_XLEN,
  parameter int unsigned DIM_W     = CV_DIM_W
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             wr_en_i,
  input  logic [SLOT_W-1:0]                wr_slot_i,
  input  logic [2:0]                       wr_funct3_i,
  input  logic [XLEN-1:0]                  wr_rs0_i,
  input  logic [XLEN-1:0]                  wr_rs1_i,
  input  logic [CV_CH_W-1:0]               wr_ch_i,
  input  logic [1:0]                       wr_pad_i,
  input  logic                             wr_stride_i,
  input  logic [SLOT_W-1:0]                rd_slot_i,
  output conv_cfg_t                        cfg_o,
  output logic [NUM_SLOTS-1:0][MASK_W-1:0] masks_o
);

  conv_cfg_t                        cfg_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0][MASK_W-1:0] mask_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) cfg_q[i] <= '0;
      mask_q <= '0;
    end else if (wr_en_i) begin
      case (wr_funct3_i)
        F3_SETADDR: begin
          cfg_q[wr_slot_i].w_addr <= wr_rs0_i;
          cfg_q[wr_slot_i].i_addr <= wr_rs1_i;
          mask_q[wr_slot_i][0]    <= 1'b1;
        end
        F3_SETIDIM: begin
          cfg_q[wr_slot_i].i_height   <= wr_rs1_i[DIM_W-1:0];
          cfg_q[wr_slot_i].i_width    <= wr_rs0_i[DIM_W-1:0];
          cfg_q[wr_slot_i].i_channels <= wr_ch_i;
          mask_q[wr_slot_i][1]        <= 1'b1;
        end
        F3_SETWDIM: begin
          cfg_q[wr_slot_i].w_height   <= wr_rs1_i[DIM_W-1:0];
          cfg_q[wr_slot_i].w_width    <= wr_rs0_i[DIM_W-1:0];
          cfg_q[wr_slot_i].w_channels <= wr_ch_i;
          cfg_q[wr_slot_i].padding    <= wr_pad_i;
          cfg_q[wr_slot_i].stride     <= wr_stride_i;
          mask_q[wr_slot_i][2]        <= 1'b1;
        end
        F3_SETRADDR: begin
          cfg_q[wr_slot_i].r_addr <= wr_rs0_i;
          mask_q[wr_slot_i][3]    <= 1'b1;
        end
        // CLR only invalidates; stale field values are harmless once the mask is zero
        F3_CLR:  mask_q[wr_slot_i] <= '0;
        default: ;
      endcase
    end
  end

  assign cfg_o   = cfg_q[rd_slot_i];
  assign masks_o = mask_q;

endmodule

// File: rtl/co_decoder_seq.sv
// Registered CV-X-IF custom-opcode decoder driving the conv engine start/result handshakes.
// Optional perf counters (funct3 110) enabled by defining CO_DECODER_PERF_CNT_EN.
module co_decoder_seq
  import cvxif_pkg::*;
#(
  parameter int unsigned XLEN          = CV_XLEN,
  parameter int unsigned NUM_SLOTS     = 4,
  parameter int unsigned ID_W          = 4,
  parameter int unsigned DIM_W         = CV_DIM_W,
  parameter logic [6:0]  CUSTOM_OPCODE = 7'b0001011
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [31:0]                  issue_instr_i,
  input  logic [XLEN-1:0]              issue_rs0_i,
  input  logic [XLEN-1:0]              issue_rs1_i,
  input  logic [ID_W-1:0]              issue_id_i,
  output x_issue_resp_t                issue_resp_o,
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic [ID_W-1:0]              result_id_o,
  output logic [4:0]                   result_rd_o,
  output logic [XLEN-1:0]              result_data_o,
  output logic                         start_valid_o,
  input  logic                         start_ready_i,
  output logic [$clog2(NUM_SLOTS)-1:0] start_slot_o,
  output conv_cfg_t                    cfg_o,
  input  logic                         busy_i
);

  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);

  dec_state_e                       state_q, state_d;
  logic [SLOT_W-1:0]                slot_q, slot_d;
  logic [ID_W-1:0]                  id_q, id_d;
  logic [4:0]                       rd_q, rd_d;
  logic [XLEN-1:0]                  data_q, data_d;
  logic [NUM_SLOTS-1:0][MASK_W-1:0] masks_c;
  logic [XLEN-1:0]                  status_c;
  x_issue_resp_t                    resp_c;

  logic [2:0]        f3_c;
  logic [SLOT_W-1:0] slot_c;
  logic              opc_match_c, is_cfg_c, is_start_c, is_status_c, is_perf_c;
  logic              legal_c, stall_c, hs_c;
  logic              unused_c;

  assign f3_c        = issue_instr_i[14:12];
  assign slot_c      = issue_instr_i[28 +: SLOT_W];
  assign opc_match_c = (issue_instr_i[6:0] == CUSTOM_OPCODE);
  assign is_cfg_c    = opc_match_c &&
                       (f3_c inside {F3_SETADDR, F3_SETIDIM, F3_SETWDIM, F3_SETRADDR, F3_CLR});
  assign is_start_c  = opc_match_c && (f3_c == F3_START);
  assign is_status_c = opc_match_c && (f3_c == F3_STATUS);
  assign legal_c     = is_cfg_c || is_start_c || is_status_c || is_perf_c;
  assign unused_c    = ^issue_instr_i;

  // Rewriting the slot the engine is consuming would corrupt its config mid-run
  assign stall_c       = is_cfg_c && busy_i && (slot_c == slot_q);
  assign issue_ready_o = (state_q == ST_IDLE) && !stall_c;
  assign hs_c          = issue_valid_i && issue_ready_o;

`ifdef CO_DECODER_PERF_CNT_EN
  logic [31:0] acc_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        perf_clr_c;

  assign is_perf_c  = opc_match_c && (f3_c == F3_PERF);
  assign perf_clr_c = hs_c && is_perf_c && issue_instr_i[26];

  // Wrapping event counters; a clearing PERF read wins over its own increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (perf_clr_c) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (hs_c && legal_c)                   acc_cnt_q   <= acc_cnt_q + 32'd1;
      if (issue_valid_i && !issue_ready_o)   stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`else
  assign is_perf_c = 1'b0;
`endif

  always_comb begin
    status_c          = XLEN'(masks_c);
    status_c[XLEN-1]  = busy_i;
  end

  co_cfg_bank #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W),
    .XLEN      (XLEN),
    .DIM_W     (DIM_W)
  ) u_cfg_bank (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wr_en_i     (hs_c && is_cfg_c),
    .wr_slot_i   (slot_c),
    .wr_funct3_i (f3_c),
    .wr_rs0_i    (issue_rs0_i),
    .wr_rs1_i    (issue_rs1_i),
    .wr_ch_i     (issue_instr_i[11:7]),
    .wr_pad_i    (issue_instr_i[27:26]),
    .wr_stride_i (issue_instr_i[25]),
    .rd_slot_i   (slot_q),
    .cfg_o       (cfg_o),
    .masks_o     (masks_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      id_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      id_q    <= id_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    id_d    = id_q;
    rd_d    = rd_q;
    data_d  = data_q;
    resp_c  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (hs_c && legal_c) begin
          resp_c.accept    = 1'b1;
          resp_c.writeback = !is_cfg_c;
          if (!is_cfg_c) begin
            id_d = issue_id_i;
            rd_d = issue_instr_i[11:7];
          end
          if (is_start_c) begin
            if (&masks_c[slot_c]) begin
              state_d = ST_LAUNCH;
              slot_d  = slot_c;
              data_d  = '0;
            end else begin
              state_d = ST_RESP;
              data_d  = XLEN'(ERR_INCOMPLETE);
            end
          end
          if (is_status_c) begin
            state_d = ST_RESP;
            data_d  = status_c;
          end
`ifdef CO_DECODER_PERF_CNT_EN
          if (is_perf_c) begin
            state_d = ST_RESP;
            data_d  = issue_instr_i[25] ? XLEN'(stall_cnt_q) : XLEN'(acc_cnt_q);
          end
`endif
        end
      end
      ST_LAUNCH: if (start_ready_i)  state_d = ST_RESP;
      ST_RESP:   if (result_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign issue_resp_o   = resp_c;
  assign start_valid_o  = (state_q == ST_LAUNCH);
  assign start_slot_o   = slot_q;
  assign result_valid_o = (state_q == ST_RESP);
  assign result_id_o    = id_q;
  assign result_rd_o    = rd_q;
  assign result_data_o  = data_q;

endmodule
